// File: rtl/gpio_rmw_pkg.sv
// gpio_rmw_pkg
//   Shared definitions for the GPIO read-modify-write arbiter:
//   - state_t       : transaction FSM states
//   - AXI_*         : AXI-Lite response codes
//   - GPIO_*        : byte offsets of the AXI GPIO register map
//   - rmw_merge()   : the read-modify-write data rule
package gpio_rmw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  localparam logic [7:0] GPIO_DATA  = 8'h00;
  localparam logic [7:0] GPIO_TRI   = 8'h04;
  localparam logic [7:0] GPIO_DATA2 = 8'h08;
  localparam logic [7:0] GPIO_TRI2  = 8'h0C;

  // Clear first, then set, so a bit present in both masks ends up set.
  function automatic logic [31:0] rmw_merge(input logic [31:0] old_val,
                                            input logic [31:0] set_bits,
                                            input logic [31:0] clr_bits);
    return (old_val & ~clr_bits) | set_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin grant selection. The search starts one position after the
//   last accepted grant and wraps. After reset the pointer sits on the last
//   requester, so requester 0 has first priority.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   req          : NREQ request lines
//   accept       : the current grant is taken; advance the pointer to it
//   grant        : one-hot grant (combinational, zero when no request)
//   grant_idx    : binary index of grant
//   grant_any    : at least one request is present
import gpio_rmw_pkg::*;

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [IW-1:0] last_q;
  int            idx;

  // Scan NREQ positions starting just after the last winner; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Pointer moves only when the grant is actually consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= IW'(NREQ - 1);
    end else if (accept && grant_any) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/gpio_rmw_arbiter.sv
// gpio_rmw_arbiter
//   Arbitrates NREQ requesters for atomic set/clear updates of AXI GPIO
//   registers. Each granted request performs AXI-Lite read, merge, write,
//   then reports the pre-modification value back to its owner.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester request and one-cycle accept pulse
//   req_addr/set/clr      : per-requester byte offset, set mask, clear mask
//   rsp_valid/data/err    : one-cycle completion pulse to owner, old value, error
//   m_axi_*               : AXI-Lite master (AR, R, AW, W, B channels)
// Build option:
//   GPIO_RMW_TIMEOUT_EN   : when defined, each AXI wait state is bounded by
//                           TIMEOUT cycles; on expiry the transaction ends
//                           with rsp_err=1 and rsp_data=0.
import gpio_rmw_pkg::*;

module gpio_rmw_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*8-1:0]  req_addr,
  input  logic [NREQ*32-1:0] req_set,
  input  logic [NREQ*32-1:0] req_clr,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic [31:0]        m_axi_awaddr,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [31:0]        m_axi_wdata,
  output logic [3:0]         m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  output logic [31:0]        m_axi_araddr,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [31:0]        m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("gpio_rmw_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
  end

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;
  logic [5:0]      sel_word;
  logic [31:0]     sel_set;
  logic [31:0]     sel_clr;
  logic [31:0]     set_q;
  logic [31:0]     clr_q;
  logic [31:0]     old_q;
  logic            tmo_hit;

  assign m_axi_wstrb = 4'hF;
  assign accept      = (state == ST_IDLE) && grant_any;

  // Only the word index of the byte offset matters; AXI GPIO is word-wide.
  assign sel_word = req_addr[int'(grant_idx)*8 + 2 +: 6];
  assign sel_set  = req_set[int'(grant_idx)*32 +: 32];
  assign sel_clr  = req_clr[int'(grant_idx)*32 +: 32];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef GPIO_RMW_TIMEOUT_EN
  state_t     prev_state;
  logic [7:0] tmo_cnt;
  logic [7:0] cyc_in_state;

  // A state change is seen as prev_state != state, which restarts the count
  // on the very first cycle of every state.
  assign cyc_in_state = (state != prev_state) ? 8'd0 : tmo_cnt;
  assign tmo_hit = (state == ST_AR || state == ST_R || state == ST_WR || state == ST_B) &&
                   (cyc_in_state == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_state <= ST_IDLE;
      tmo_cnt    <= 8'd0;
    end else begin
      prev_state <= state;
      tmo_cnt    <= cyc_in_state + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction FSM. All outputs are registered; req_ready and rsp_valid
  // default low each cycle so they form single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      owner         <= '0;
      set_q         <= '0;
      clr_q         <= '0;
      old_q         <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      if (tmo_hit) begin
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        rsp_valid     <= owner;
        rsp_data      <= '0;
        rsp_err       <= 1'b1;
        state         <= ST_RSP;
      end else begin
        case (state)
          ST_IDLE: begin
            if (grant_any) begin
              req_ready     <= grant;
              owner         <= grant;
              set_q         <= sel_set;
              clr_q         <= sel_clr;
              m_axi_araddr  <= {24'h0, sel_word, 2'b00};
              m_axi_arvalid <= 1'b1;
              state         <= ST_AR;
            end
          end
          ST_AR: begin
            if (m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              m_axi_rready  <= 1'b1;
              state         <= ST_R;
            end
          end
          ST_R: begin
            if (m_axi_rvalid) begin
              m_axi_rready <= 1'b0;
              old_q        <= m_axi_rdata;
              if (m_axi_rresp != AXI_OKAY) begin
                rsp_valid <= owner;
                rsp_data  <= m_axi_rdata;
                rsp_err   <= 1'b1;
                state     <= ST_RSP;
              end else begin
                m_axi_awaddr  <= m_axi_araddr;
                m_axi_wdata   <= rmw_merge(m_axi_rdata, set_q, clr_q);
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                state         <= ST_WR;
              end
            end
          end
          ST_WR: begin
            // AW and W complete independently; move on once neither is pending.
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
              m_axi_awvalid <= 1'b0;
              m_axi_wvalid  <= 1'b0;
              m_axi_bready  <= 1'b1;
              state         <= ST_B;
            end
          end
          ST_B: begin
            if (m_axi_bvalid) begin
              m_axi_bready <= 1'b0;
              rsp_valid    <= owner;
              rsp_data     <= old_q;
              rsp_err      <= (m_axi_bresp != AXI_OKAY);
              state        <= ST_RSP;
            end
          end
          ST_RSP: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_rmw_arbiter.md
GPIO_RMW_ARBITER -- requirements
Module: gpio_rmw_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (8-bit).
REQ-003 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester RMW request.
REQ-006 SHALL have port req_ready  out  NREQ  one-cycle grant/accept pulse.
REQ-007 SHALL have port req_addr  in  NREQ*8  register byte offset per requester.
REQ-008 SHALL have port req_set  in  NREQ*32  bits to set.
REQ-009 SHALL have port req_clr  in  NREQ*32  bits to clear.
REQ-010 SHALL have port rsp_valid  out  NREQ  one-cycle completion pulse to owner.
REQ-011 SHALL have port rsp_data  out  32  register value before modification.
REQ-012 SHALL have port rsp_err  out  1  completion failed; qualified by rsp_valid.
REQ-013 SHALL have AXI-Lite master ports m_axi_awaddr out 32, m_axi_awvalid out 1, m_axi_awready in 1.
REQ-014 SHALL have m_axi_wdata out 32, m_axi_wstrb out 4 (constant 4'hF), m_axi_wvalid out 1, m_axi_wready in 1.
REQ-015 SHALL have m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-016 SHALL have m_axi_araddr out 32, m_axi_arvalid out 1, m_axi_arready in 1.
REQ-017 SHALL have m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.

Function
REQ-018 SHALL run FSM IDLE -> AR -> R -> WR -> B -> RSP -> IDLE, one transaction at a time.
REQ-019 SHALL in IDLE grant round-robin, search starting at (last grant + 1) mod NREQ; grant pulses req_ready and latches addr/set/clr in the same cycle; no request -> stay IDLE.
REQ-020 SHALL in AR drive arvalid=1, araddr={24'h0, addr[7:2], 2'b00} until arready sampled high.
REQ-021 SHALL in R hold rready=1; on rvalid latch rdata; rresp!=2'b00 -> go to RSP with err=1, no write issued.
REQ-022 SHALL in WR assert awvalid and wvalid together, each deasserted independently after its ready; wdata=(old & ~clr) | set (set wins on overlap); leave WR when both accepted.
REQ-023 SHALL in B hold bready=1; on bvalid set err=(bresp!=2'b00).
REQ-024 SHALL in RSP pulse rsp_valid of owner one cycle with rsp_data=old and rsp_err, then IDLE; earliest next grant is the following cycle.
REQ-025 SHALL ignore req_valid changes while busy; withdrawn-then-reasserted requests compete normally.

Reset
REQ-026 SHALL on rst_n=0 (any state, incl. mid-transaction) go IDLE, zero all AXI valid/ready outputs, req_ready, rsp_valid, rsp_data, rsp_err, addresses, wdata, and set round-robin pointer so requester 0 wins first.

Configuration
REQ-027 SHALL with GPIO_RMW_TIMEOUT_EN defined count cycles in AR/R/WR/B (reset on state entry); at TIMEOUT, drop all AXI valids/readies, go RSP with rsp_err=1, rsp_data=0.
REQ-028 SHALL without GPIO_RMW_TIMEOUT_EN wait indefinitely in each state; no counter logic synthesized.

Structure
REQ-029 SHALL place state enum, AXI response constants (OKAY=2'b00) and GPIO register offsets (0x00 DATA, 0x04 TRI, 0x08 DATA2, 0x0C TRI2) in package gpio_rmw_pkg.
REQ-030 SHALL implement grant selection in sub-module rr_arbiter (NREQ request in, one-hot grant out, pointer update on accept).

Verification
REQ-031 SHALL cover: req0 addr 0x04, set=0x0F, clr=0; slave holds 0xF0F0_0000 -> write 0xF0F0_000F, rsp_data=0xF0F0_0000, rsp_err=0.
REQ-032 SHALL cover: req1 set=clr=0x1 on value 0x0 -> written 0x1.
REQ-033 SHALL cover: req0..3 asserted continuously -> grants 0,1,2,3,0 in order, no overlap of transactions.
REQ-034 SHALL cover: rresp=2'b10 -> no AW/W issued, rsp_err=1; bresp=2'b10 -> rsp_err=1.
REQ-035 SHALL cover: awready 3 cycles before wready and vice versa -> exactly one AW and one W handshake each.
REQ-036 SHALL cover: rst_n low during WR -> next cycle all valids 0, state IDLE; with GPIO_RMW_TIMEOUT_EN, arready stuck 0 -> rsp_err=1 after 255 cycles.
